dffe_feed_serializer: RTL and testbench

// - Upstream feeder for the synthesized enable-flop stage (din/en -> dout).
// - Accepts a parallel word over a valid/ready handshake.
// - Emits the word one bit at a time on din, with a one-cycle en strobe per bit, every DIV cycles.
// - The downstream stage captures din only when en=1. Between strobes it holds its output.

---
 rtl/dffe_feed_if.sv | 23 ++
 rtl/dffe_feed_serializer.sv | 133 +++++++++++++
 tb/tb_dffe_feed_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dffe_feed_if.sv
// Word-in / serial-out bundle between an upstream word source and dffe_feed_serializer.
// The master side offers words; the slave side (the serializer) drives the serial strobe outputs.
interface dffe_feed_if #(
  parameter int W = 8
);
  logic [W-1:0] word_in;
  logic         word_valid;
  logic         word_ready;
  logic         din;
  logic         en;
  logic         busy;
  logic         done;

  modport master (
    output word_in, word_valid,
    input  word_ready, din, en, busy, done
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, din, en, busy, done
  );
endinterface

// File: rtl/dffe_feed_serializer.sv
// Serializes a parallel word onto din with a one-cycle en strobe every DIV cycles.
// Optional even-parity trailer bit is built when DFFE_FEED_PARITY_EN is defined.
module dffe_feed_serializer #(
  parameter int W         = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  dffe_feed_if.slave  bus
);

`ifdef DFFE_FEED_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q,   state_d;
  logic [N-1:0]   shreg_q,   shreg_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           din_q,     din_d;
  logic           en_q,      en_d;
  logic           busy_q,    busy_d;
  logic           done_q,    done_d;
  logic           ready_q,   ready_d;

  logic           accept;
  logic [N-1:0]   load_word;
  logic           cur_bit;
  logic [N-1:0]   shifted;

  // The parity bit sits at the far end of the shift register so it leaves after the data bits.
`ifdef DFFE_FEED_PARITY_EN
  assign load_word = (MSB_FIRST != 0) ? {bus.word_in, ^bus.word_in}
                                      : {^bus.word_in, bus.word_in};
`else
  assign load_word = bus.word_in;
`endif

  assign accept  = bus.word_valid && ready_q;
  assign cur_bit = (MSB_FIRST != 0) ? shreg_q[N-1] : shreg_q[0];
  assign shifted = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    din_d     = din_q;
    en_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ready_d   = ready_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          state_d   = SHIFT;
          shreg_d   = load_word;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end

      SHIFT: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        // bit_cnt reaches N in the cycle the last strobe is visible, so done lands one cycle later for any DIV.
        if (bit_cnt_q == BCW'(N)) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          done_d    = 1'b1;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
        end else begin
          if (div_cnt_q == '0) begin
            en_d      = 1'b1;
            din_d     = cur_bit;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shreg_d   = shifted;
          end
          div_cnt_d = (div_cnt_q == DCW'(DIV - 1)) ? '0 : div_cnt_q + DCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      din_q     <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      din_q     <= din_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.word_ready = ready_q;
  assign bus.din        = din_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_dffe_feed_serializer.sv
// Directed bench: three serializer instances (DIV=4 LSB-first, DIV=1, DIV=2 MSB-first) sharing clk/rst.
module tb_dffe_feed_serializer;

`ifdef DFFE_FEED_PARITY_EN
  localparam int N_TB = 9;
`else
  localparam int N_TB = 8;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [7:0] win [3];
  logic       wv  [3];
  logic       en_s [3];
  logic       din_s [3];
  logic       busy_s [3];
  logic       done_s [3];
  logic       rdy_s [3];

  dffe_feed_if #(.W(8)) if0 ();
  dffe_feed_if #(.W(8)) if1 ();
  dffe_feed_if #(.W(8)) if2 ();

  dffe_feed_serializer #(.W(8), .DIV(4), .MSB_FIRST(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dffe_feed_serializer #(.W(8), .DIV(1), .MSB_FIRST(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
  dffe_feed_serializer #(.W(8), .DIV(2), .MSB_FIRST(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.word_in = win[0];  assign if0.word_valid = wv[0];
  assign if1.word_in = win[1];  assign if1.word_valid = wv[1];
  assign if2.word_in = win[2];  assign if2.word_valid = wv[2];

  assign en_s[0] = if0.en;  assign din_s[0] = if0.din;  assign busy_s[0] = if0.busy;
  assign done_s[0] = if0.done;  assign rdy_s[0] = if0.word_ready;
  assign en_s[1] = if1.en;  assign din_s[1] = if1.din;  assign busy_s[1] = if1.busy;
  assign done_s[1] = if1.done;  assign rdy_s[1] = if1.word_ready;
  assign en_s[2] = if2.en;  assign din_s[2] = if2.din;  assign busy_s[2] = if2.busy;
  assign done_s[2] = if2.done;  assign rdy_s[2] = if2.word_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (rdy_s[idx] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rdy_s[idx] !== 1'b1) begin
      fails++;
      $display("FAIL wait_ready[%0d]: word_ready=%b after %0d cycles, required 1", idx, rdy_s[idx], n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({en_s[i], din_s[i], busy_s[i], done_s[i], rdy_s[i]} !== 5'b0) begin
        fails++;
        $display("FAIL reset_state[%0d]: en,din,busy,done,ready=%b required 00000", i,
                 {en_s[i], din_s[i], busy_s[i], done_s[i], rdy_s[i]});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rdy_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || done_s[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_release[%0d]: ready=%b busy=%b done=%b required 1 0 0", i,
                 rdy_s[i], busy_s[i], done_s[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    logic       exp_en, exp_done, exp_din, last_din;
    int         strobe, last_c;
    w = 8'hA5;
    strobe = 0;
    last_din = 1'b0;
    last_c = 1 + 4 * (N_TB - 1);
    wait_ready(0);
    win[0] = w;
    wv[0] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    tests++;
    if (busy_s[0] !== 1'b1 || rdy_s[0] !== 1'b0 || en_s[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_accept: busy=%b ready=%b en=%b required 1 0 0", busy_s[0], rdy_s[0], en_s[0]);
    end
    for (int c = 1; c <= last_c + 3; c++) begin
      @(negedge clk);
      exp_en   = (c <= last_c) && ((c - 1) % 4 == 0);
      exp_done = (c == last_c + 1);
      tests++;
      if (en_s[0] !== exp_en || done_s[0] !== exp_done || busy_s[0] !== (c <= last_c)
          || rdy_s[0] !== (c > last_c)) begin
        fails++;
        $display("FAIL basic_timing c=%0d: en=%b done=%b busy=%b ready=%b required %b %b %b %b", c,
                 en_s[0], done_s[0], busy_s[0], rdy_s[0], exp_en, exp_done, c <= last_c, c > last_c);
      end
      if (exp_en) begin
        exp_din = (strobe < 8) ? w[strobe] : ^w;
        last_din = exp_din;
        strobe++;
      end
      tests++;
      if (din_s[0] !== last_din) begin
        fails++;
        $display("FAIL basic_din c=%0d: din=%b required %b", c, din_s[0], last_din);
      end
    end
  endtask

  task automatic test_ignored_while_busy();
    logic [7:0] w;
    logic       exp_din;
    int         strobe, last_c;
    w = 8'h3C;
    strobe = 0;
    last_c = 1 + 4 * (N_TB - 1);
    wait_ready(0);
    win[0] = w;
    wv[0] = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= last_c + 1; c++) begin
      win[0] = 8'($urandom);
      wv[0] = (c < last_c) ? c[0] : 1'b0;
      @(negedge clk);
      if (en_s[0] === 1'b1) begin
        exp_din = (strobe < 8) ? w[strobe] : ^w;
        tests++;
        if (din_s[0] !== exp_din) begin
          fails++;
          $display("FAIL ignored_din strobe=%0d: din=%b required %b", strobe, din_s[0], exp_din);
        end
        strobe++;
      end
      tests++;
      if (rdy_s[0] !== (c > last_c) || done_s[0] !== (c == last_c + 1)) begin
        fails++;
        $display("FAIL ignored_ready c=%0d: ready=%b done=%b required %b %b", c, rdy_s[0], done_s[0],
                 c > last_c, c == last_c + 1);
      end
    end
    wv[0] = 1'b0;
    tests++;
    if (strobe != N_TB) begin
      fails++;
      $display("FAIL ignored_count: strobes=%0d required %0d", strobe, N_TB);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_din, exp_done;
    int   strobe;
    strobe = 0;
    wait_ready(1);
    win[1] = 8'hFF;
    wv[1] = 1'b1;
    @(negedge clk);
    win[1] = 8'h00;
    for (int c = 1; c <= 2 * N_TB + 4; c++) begin
      @(negedge clk);
      if (c == N_TB + 2) wv[1] = 1'b0;
      exp_en   = (c >= 1 && c <= N_TB) || (c >= N_TB + 3 && c <= 2 * N_TB + 2);
      exp_done = (c == N_TB + 1) || (c == 2 * N_TB + 3);
      // 0xFF has even parity 0, 0x00 likewise, so only the data bits of the first word are 1.
      exp_din  = (c <= 8) ? 1'b1 : 1'b0;
      tests++;
      if (en_s[1] !== exp_en || done_s[1] !== exp_done) begin
        fails++;
        $display("FAIL b2b_timing c=%0d: en=%b done=%b required %b %b", c, en_s[1], done_s[1],
                 exp_en, exp_done);
      end
      if (exp_en) begin
        strobe++;
        tests++;
        if (din_s[1] !== exp_din) begin
          fails++;
          $display("FAIL b2b_din c=%0d: din=%b required %b", c, din_s[1], exp_din);
        end
      end
      if (c == N_TB + 1) begin
        tests++;
        if (rdy_s[1] !== 1'b1 || busy_s[1] !== 1'b0) begin
          fails++;
          $display("FAIL b2b_done_cycle: ready=%b busy=%b required 1 0", rdy_s[1], busy_s[1]);
        end
      end
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    logic       exp_en, exp_din;
    int         strobe, last_c;
    w = 8'h80;
    strobe = 0;
    last_c = 1 + 2 * (N_TB - 1);
    wait_ready(2);
    win[2] = w;
    wv[2] = 1'b1;
    @(negedge clk);
    wv[2] = 1'b0;
    for (int c = 1; c <= last_c + 2; c++) begin
      @(negedge clk);
      exp_en = (c <= last_c) && ((c - 1) % 2 == 0);
      tests++;
      if (en_s[2] !== exp_en || done_s[2] !== (c == last_c + 1)) begin
        fails++;
        $display("FAIL msb_timing c=%0d: en=%b done=%b required %b %b", c, en_s[2], done_s[2],
                 exp_en, c == last_c + 1);
      end
      if (exp_en) begin
        exp_din = (strobe < 8) ? w[7 - strobe] : ^w;
        tests++;
        if (din_s[2] !== exp_din) begin
          fails++;
          $display("FAIL msb_din strobe=%0d: din=%b required %b", strobe, din_s[2], exp_din);
        end
        strobe++;
      end
    end
  endtask

  task automatic test_parity();
    int   strobes, dones;
    logic ninth;
    strobes = 0;
    dones = 0;
    ninth = 1'b0;
    wait_ready(0);
    win[0] = 8'h07;
    wv[0] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (en_s[0] === 1'b1) begin
        strobes++;
        if (strobes == 9) ninth = din_s[0];
      end
      if (done_s[0] === 1'b1) dones++;
    end
    tests++;
    if (strobes != N_TB || dones != 1) begin
      fails++;
      $display("FAIL parity_count: strobes=%0d dones=%0d required %0d 1", strobes, dones, N_TB);
    end
`ifdef DFFE_FEED_PARITY_EN
    tests++;
    if (ninth !== 1'b1) begin
      fails++;
      $display("FAIL parity_bit: din=%b required 1", ninth);
    end
`endif
  endtask

  task automatic test_reset_mid_word();
    int strobes;
    strobes = 0;
    wait_ready(0);
    win[0] = 8'hA5;
    wv[0] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (en_s[0] === 1'b1) strobes++;
    end
    tests++;
    if (strobes != 3 || busy_s[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: strobes=%0d busy=%b required 3 1", strobes, busy_s[0]);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({en_s[0], din_s[0], busy_s[0], done_s[0], rdy_s[0]} !== 5'b0) begin
      fails++;
      $display("FAIL midrst_async: en,din,busy,done,ready=%b required 00000",
               {en_s[0], din_s[0], busy_s[0], done_s[0], rdy_s[0]});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (rdy_s[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_release: ready=%b required 0", rdy_s[0]);
    end
    @(negedge clk);
    tests++;
    if (rdy_s[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_ready: ready=%b required 1", rdy_s[0]);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tests++;
      if (done_s[0] !== 1'b0 || en_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
        fails++;
        $display("FAIL midrst_quiet c=%0d: done=%b en=%b busy=%b required 0 0 0", c,
                 done_s[0], en_s[0], busy_s[0]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 3; i++) begin
      win[i] = 8'h00;
      wv[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_ignored_while_busy();
    test_back_to_back();
    test_msb_first();
    test_parity();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
